// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - boundary mode and direction encodings for the up/down counter
package counter_pkg;
   localparam logic [1:0] MODE_WRAP   = 2'b00;
   localparam logic [1:0] MODE_SAT    = 2'b01;
   localparam logic [1:0] MODE_BOUNCE = 2'b10;
   localparam logic       DIR_UP      = 1'b0;
   localparam logic       DIR_DN      = 1'b1;
endpackage

// File: rtl/prescaler_tick.sv
// rtl/prescaler_tick.sv - divides enabled clock cycles into one step tick every PRESCALE cycles
module prescaler_tick #(
   parameter int PRESCALE = 1
) (
   input  logic CLK,
   input  logic RST,
   input  logic EN,
   input  logic CLR,
   output logic TICK
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pcnt;

   assign TICK = EN && (pcnt == LAST);

   always_ff @(posedge CLK) begin
      if (RST || CLR) begin
         pcnt <= '0;
      end else if (TICK) begin
         pcnt <= '0;
      end else if (EN) begin
         pcnt <= pcnt + 1'b1;
      end
   end
endmodule

// File: rtl/updown_counter_n.sv
// rtl/updown_counter_n.sv - parametrised up/down LED counter with load, prescaler and wrap/saturate/bounce limits
module updown_counter_n
   import counter_pkg::*;
#(
   parameter int WIDTH    = 3,
   parameter int MAX_VAL  = 7,
   parameter int PRESCALE = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             DIR,
   input  logic [1:0]       MODE,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] LOAD_VAL,
   output logic [WIDTH-1:0] LED,
   output logic             TC,
   output logic             DIR_OUT
);
   localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX_VAL);

   logic             step;
   logic             bdir;
   logic             bounce;
   logic             go_up;
   logic             at_top;
   logic             at_bot;
   logic [WIDTH-1:0] led_nxt;
   logic             tc_nxt;
   logic             bdir_nxt;

   prescaler_tick #(.PRESCALE(PRESCALE)) u_pre (
      .CLK  (CLK),
      .RST  (RST),
      .EN   (EN),
      .CLR  (LOAD),
      .TICK (step)
   );

   assign bounce = (MODE == MODE_BOUNCE);
   assign go_up  = bounce ? (bdir == DIR_UP) : (DIR == DIR_UP);
   // Limits are compared explicitly so MAX_VAL = 2^WIDTH-1 never relies on overflow
   assign at_top = (LED == TOP);
   assign at_bot = (LED == '0);

   always_comb begin
      led_nxt  = LED;
      tc_nxt   = 1'b0;
      bdir_nxt = bounce ? bdir : DIR;
      if (LOAD) begin
         led_nxt = (LOAD_VAL > TOP) ? TOP : LOAD_VAL;
      end else if (step) begin
         if (go_up && !at_top) begin
            led_nxt = LED + 1'b1;
         end else if (!go_up && !at_bot) begin
            led_nxt = LED - 1'b1;
         end else begin
            tc_nxt = 1'b1;
            case (MODE)
               MODE_SAT: led_nxt = LED;
               MODE_BOUNCE: begin
                  led_nxt  = go_up ? (TOP - 1'b1) : WIDTH'(1);
                  bdir_nxt = go_up ? DIR_DN : DIR_UP;
               end
               default: led_nxt = go_up ? '0 : TOP;
            endcase
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         LED  <= '0;
         TC   <= 1'b0;
         bdir <= DIR_UP;
      end else begin
         LED  <= led_nxt;
         TC   <= tc_nxt;
         bdir <= bdir_nxt;
      end
   end

   // Outside bounce mode bdir follows DIR every cycle, so it is the effective direction
   assign DIR_OUT = bdir;
endmodule

// File: tb/tb_updown_counter_n.sv
// tb/tb_updown_counter_n.sv - self-checking bench for updown_counter_n over three parameter sets
module tb_updown_counter_n;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       dir = 1'b0;
   logic       load = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [3:0] load_val = 4'd0;

   logic [2:0] led_a, led_b;
   logic [3:0] led_c;
   logic       tc_a, tc_b, tc_c, do_a, do_b, do_c;

   int checks = 0;
   int errors = 0;

   int mx[3]    = '{7, 5, 15};
   int ps[3]    = '{1, 4, 1};
   int lmask[3] = '{7, 7, 15};
   int m_led[3], m_pc[3], m_bdir[3], m_tc[3];

   typedef struct {
      logic       r, e, d;
      logic [1:0] m;
      logic       l;
      logic [3:0] lv;
      int         led, tc, dout;
   } vec_t;
   vec_t vt[$];

   always #5 clk = ~clk;

   updown_counter_n #(.WIDTH(3), .MAX_VAL(7), .PRESCALE(1)) dut_a (
      .CLK(clk), .RST(rst), .EN(en), .DIR(dir), .MODE(mode), .LOAD(load),
      .LOAD_VAL(load_val[2:0]), .LED(led_a), .TC(tc_a), .DIR_OUT(do_a));
   updown_counter_n #(.WIDTH(3), .MAX_VAL(5), .PRESCALE(4)) dut_b (
      .CLK(clk), .RST(rst), .EN(en), .DIR(dir), .MODE(mode), .LOAD(load),
      .LOAD_VAL(load_val[2:0]), .LED(led_b), .TC(tc_b), .DIR_OUT(do_b));
   updown_counter_n #(.WIDTH(4), .MAX_VAL(15), .PRESCALE(1)) dut_c (
      .CLK(clk), .RST(rst), .EN(en), .DIR(dir), .MODE(mode), .LOAD(load),
      .LOAD_VAL(load_val), .LED(led_c), .TC(tc_c), .DIR_OUT(do_c));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: counts range over 0..mx with plain integer arithmetic
   task automatic model_update();
      for (int i = 0; i < 3; i++) begin
         int lv;
         bit stp;
         bit up;
         if (rst) begin
            m_led[i] = 0; m_tc[i] = 0; m_pc[i] = 0; m_bdir[i] = 0;
         end else if (load) begin
            lv = int'(load_val) & lmask[i];
            m_led[i] = (lv > mx[i]) ? mx[i] : lv;
            m_tc[i] = 0;
            m_pc[i] = 0;
            if (mode != 2'b10) m_bdir[i] = int'(dir);
         end else begin
            stp = en && (m_pc[i] == ps[i] - 1);
            if (en) m_pc[i] = stp ? 0 : m_pc[i] + 1;
            m_tc[i] = 0;
            if (mode != 2'b10) m_bdir[i] = int'(dir);
            if (stp) begin
               up = (m_bdir[i] == 0);
               case (mode)
                  2'b01: begin
                     if (up) begin
                        if (m_led[i] == mx[i]) m_tc[i] = 1; else m_led[i]++;
                     end else begin
                        if (m_led[i] == 0) m_tc[i] = 1; else m_led[i]--;
                     end
                  end
                  2'b10: begin
                     if (up && m_led[i] == mx[i]) begin
                        m_led[i] = mx[i] - 1; m_bdir[i] = 1; m_tc[i] = 1;
                     end else if (!up && m_led[i] == 0) begin
                        m_led[i] = 1; m_bdir[i] = 0; m_tc[i] = 1;
                     end else begin
                        m_led[i] = up ? m_led[i] + 1 : m_led[i] - 1;
                     end
                  end
                  default: begin
                     if (up) begin
                        m_tc[i] = (m_led[i] == mx[i]) ? 1 : 0;
                        m_led[i] = (m_led[i] + 1) % (mx[i] + 1);
                     end else begin
                        m_tc[i] = (m_led[i] == 0) ? 1 : 0;
                        m_led[i] = (m_led[i] + mx[i]) % (mx[i] + 1);
                     end
                  end
               endcase
            end
         end
      end
   endtask

   task automatic check_model();
      chk("a_led", 32'(led_a), 32'(m_led[0]));
      chk("a_tc", 32'(tc_a), 32'(m_tc[0]));
      chk("a_dir_out", 32'(do_a), 32'(m_bdir[0]));
      chk("b_led", 32'(led_b), 32'(m_led[1]));
      chk("b_tc", 32'(tc_b), 32'(m_tc[1]));
      chk("b_dir_out", 32'(do_b), 32'(m_bdir[1]));
      chk("c_led", 32'(led_c), 32'(m_led[2]));
      chk("c_tc", 32'(tc_c), 32'(m_tc[2]));
      chk("c_dir_out", 32'(do_c), 32'(m_bdir[2]));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_update();
      #1;
      check_model();
   endtask

   task automatic add(input logic r, e, d, input logic [1:0] m, input logic l,
                      input logic [3:0] lv, input int led, tc, dout);
      vec_t v;
      v.r = r; v.e = e; v.d = d; v.m = m; v.l = l; v.lv = lv;
      v.led = led; v.tc = tc; v.dout = dout;
      vt.push_back(v);
   endtask

   initial begin
      //  r  e  d  mode  l  lv   led tc do
      add(0, 1, 0, 2'd0, 1, 4'd6, 6, 0, 0);
      add(0, 1, 0, 2'd0, 0, 4'd0, 7, 0, 0);
      add(0, 1, 0, 2'd0, 0, 4'd0, 0, 1, 0);
      add(0, 1, 0, 2'd0, 0, 4'd0, 1, 0, 0);
      add(0, 1, 1, 2'd0, 0, 4'd0, 0, 0, 1);
      add(0, 1, 1, 2'd0, 0, 4'd0, 7, 1, 1);
      add(0, 0, 1, 2'd0, 0, 4'd0, 7, 0, 1);
      add(0, 1, 0, 2'd1, 1, 4'd5, 5, 0, 0);
      add(0, 1, 0, 2'd1, 0, 4'd0, 6, 0, 0);
      add(0, 1, 0, 2'd1, 0, 4'd0, 7, 0, 0);
      add(0, 1, 0, 2'd1, 0, 4'd0, 7, 1, 0);
      add(0, 1, 0, 2'd1, 0, 4'd0, 7, 1, 0);
      add(0, 1, 1, 2'd1, 1, 4'd0, 0, 0, 1);
      add(0, 1, 1, 2'd1, 0, 4'd0, 0, 1, 1);
      add(0, 1, 0, 2'd0, 1, 4'd5, 5, 0, 0);
      add(0, 1, 0, 2'd2, 0, 4'd0, 6, 0, 0);
      add(0, 1, 1, 2'd2, 0, 4'd0, 7, 0, 0);
      add(0, 1, 0, 2'd2, 0, 4'd0, 6, 1, 1);
      add(0, 1, 0, 2'd2, 0, 4'd0, 5, 0, 1);
      add(1, 1, 0, 2'd0, 1, 4'd3, 0, 0, 0);

      rst = 1'b1; en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk("rst_led", 32'(led_a), 32'd0);
         chk("rst_tc", 32'(tc_a), 32'd0);
      end

      foreach (vt[i]) begin
         rst = vt[i].r; en = vt[i].e; dir = vt[i].d; mode = vt[i].m;
         load = vt[i].l; load_val = vt[i].lv;
         cyc();
         chk($sformatf("vec%0d_led", i), 32'(led_a), 32'(vt[i].led));
         chk($sformatf("vec%0d_tc", i), 32'(tc_a), 32'(vt[i].tc));
         chk($sformatf("vec%0d_dir_out", i), 32'(do_a), 32'(vt[i].dout));
      end

      // Prescaled instance: clamp, step every 4th cycle, freeze, load on a step cycle
      rst = 1'b1; load = 1'b0; cyc();
      rst = 1'b0; mode = 2'd0; dir = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'd7;
      cyc();
      chk("b_clamp", 32'(led_b), 32'd5);
      load = 1'b0;
      repeat (3) cyc();
      chk("b_pre_hold", 32'(led_b), 32'd5);
      cyc();
      chk("b_wrap_led", 32'(led_b), 32'd0);
      chk("b_wrap_tc", 32'(tc_b), 32'd1);
      cyc(); cyc();
      en = 1'b0;
      repeat (3) cyc();
      chk("b_freeze", 32'(led_b), 32'd0);
      en = 1'b1;
      cyc();
      chk("b_resume_wait", 32'(led_b), 32'd0);
      cyc();
      chk("b_resume_step", 32'(led_b), 32'd1);
      repeat (3) cyc();
      load = 1'b1; load_val = 4'd4;
      cyc();
      chk("b_load_on_step", 32'(led_b), 32'd4);
      load = 1'b0;
      repeat (3) cyc();
      chk("b_load_restart", 32'(led_b), 32'd4);
      cyc();
      chk("b_after_load", 32'(led_b), 32'd5);
      rst = 1'b1; load = 1'b1; load_val = 4'd3;
      cyc();
      chk("b_rst_over_load", 32'(led_b), 32'd0);

      // Wide instance: wrap down through zero, bounce down, reset mid-count
      rst = 1'b0; load = 1'b0; mode = 2'd0; dir = 1'b1; en = 1'b1;
      cyc();
      chk("c_wrap_dn_led", 32'(led_c), 32'd15);
      chk("c_wrap_dn_tc", 32'(tc_c), 32'd1);
      cyc();
      chk("c_dn_led", 32'(led_c), 32'd14);
      mode = 2'd2;
      cyc();
      chk("c_bounce_dn", 32'(led_c), 32'd13);
      chk("c_bounce_dir", 32'(do_c), 32'd1);
      rst = 1'b1;
      cyc();
      chk("c_rst_led", 32'(led_c), 32'd0);
      chk("c_rst_dir", 32'(do_c), 32'd0);
      rst = 1'b0;
      cyc();
      chk("c_bdir_up_led", 32'(led_c), 32'd1);
      chk("c_bdir_up_dir", 32'(do_c), 32'd0);

      for (int i = 0; i < 3000; i++) begin
         rst  = ($urandom_range(0, 63) == 0);
         load = ($urandom_range(0, 15) == 0);
         en   = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) dir = 1'($urandom);
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
         load_val = 4'($urandom);
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
